// File: rtl/decode_queue_ctrl_if.sv
// Signal bundle between the fetch/decode/rename environment and decode_queue_ctrl.
// Names are seen from the controller: i_* flow into it, o_* flow out of it.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface decode_queue_ctrl_if #(
  parameter int ADDR_W = `ADDR_WIDTH
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Fetch: i_fetch_valid/o_fetch_ready. Ready never depends on valid. Decode: o_dec_valid/i_rename_ready,
  // with o_dec_fire marking the transfer.
  logic              i_fetch_valid;
  logic [31:0]       i_fetch_instr;
  logic [ADDR_W-1:0] i_fetch_pc;
  logic              i_fetch_guesses_branch;
  logic [ADDR_W-1:0] i_fetch_prediction;
  logic              o_fetch_ready;

  logic              o_dec_valid;
  logic [31:0]       o_dec_instr;
  logic [ADDR_W-1:0] o_dec_pc;
  logic              o_dec_guesses_branch;
  logic [ADDR_W-1:0] o_dec_prediction;
  logic              i_dec_inconsistency;
  logic [ADDR_W-1:0] i_dec_new_pc;
  logic              i_rename_ready;
  logic              o_dec_fire;

  logic              i_flush;
  logic [ADDR_W-1:0] i_flush_pc;
  logic              o_redirect_valid;
  logic [ADDR_W-1:0] o_redirect_pc;

  logic              o_dbg_drop;

  modport slave (
    input  i_fetch_valid, i_fetch_instr, i_fetch_pc, i_fetch_guesses_branch, i_fetch_prediction,
    input  i_dec_inconsistency, i_dec_new_pc, i_rename_ready, i_flush, i_flush_pc,
    output o_fetch_ready, o_dec_valid, o_dec_instr, o_dec_pc, o_dec_guesses_branch,
    output o_dec_prediction, o_dec_fire, o_redirect_valid, o_redirect_pc, o_dbg_drop
  );

  modport master (
    output i_fetch_valid, i_fetch_instr, i_fetch_pc, i_fetch_guesses_branch, i_fetch_prediction,
    output i_dec_inconsistency, i_dec_new_pc, i_rename_ready, i_flush, i_flush_pc,
    input  o_fetch_ready, o_dec_valid, o_dec_instr, o_dec_pc, o_dec_guesses_branch,
    input  o_dec_prediction, o_dec_fire, o_redirect_valid, o_redirect_pc, o_dbg_drop
  );
endinterface

// File: rtl/decode_queue_ctrl.sv
// Instruction queue in front of the decoder; converts mispredicts and flushes into a
// single registered fetch redirect, then drops FETCH_LAT cycles of wrong-path fetch data.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module decode_queue_ctrl #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = `ADDR_WIDTH,
  parameter int FETCH_LAT = 2
) (
  input logic              clk,
  input logic              rst_n,
  decode_queue_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(FETCH_LAT + 1);

  typedef enum logic {ST_RUN = 1'b0, ST_DROP = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic               redir_valid_q, redir_valid_d;
  logic [ADDR_W-1:0]  redir_pc_q, redir_pc_d;

  logic [31:0]        instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
  logic               gb_mem_q    [DEPTH];
  logic [ADDR_W-1:0]  pred_mem_q  [DEPTH];

  logic fetch_ready, dec_valid, fire, mispredict, kill, push;

  assign fetch_ready = (count_q < (PTR_W+1)'(DEPTH)) | (state_q == ST_DROP);
  assign dec_valid   = (count_q != '0) & (state_q == ST_RUN);
  assign fire        = dec_valid & bus.i_rename_ready & ~bus.i_flush;
  // A decoder inconsistency that lands on the PC fetch already chose needs no redirect.
  assign mispredict  = fire & bus.i_dec_inconsistency &
                       (bus.i_dec_new_pc != pred_mem_q[rd_ptr_q]);
  assign kill        = bus.i_flush | mispredict;
  assign push        = bus.i_fetch_valid & fetch_ready & (state_q == ST_RUN) & ~kill;

  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    drop_d        = drop_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    if (kill) begin
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      state_d       = ST_DROP;
      drop_d        = CNT_W'(FETCH_LAT);
      redir_valid_d = 1'b1;
      redir_pc_d    = bus.i_flush ? bus.i_flush_pc : bus.i_dec_new_pc;
    end else begin
      if (state_q == ST_DROP) begin
        drop_d = drop_q - 1'b1;
        if (drop_q <= CNT_W'(1)) state_d = ST_RUN;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (fire) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      drop_q        <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      drop_q        <= drop_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.i_fetch_instr;
      pc_mem_q[wr_ptr_q]    <= bus.i_fetch_pc;
      gb_mem_q[wr_ptr_q]    <= bus.i_fetch_guesses_branch;
      pred_mem_q[wr_ptr_q]  <= bus.i_fetch_prediction;
    end
  end

  assign bus.o_fetch_ready        = fetch_ready;
  assign bus.o_dec_valid          = dec_valid;
  assign bus.o_dec_instr          = instr_mem_q[rd_ptr_q];
  assign bus.o_dec_pc             = pc_mem_q[rd_ptr_q];
  assign bus.o_dec_guesses_branch = gb_mem_q[rd_ptr_q];
  assign bus.o_dec_prediction     = pred_mem_q[rd_ptr_q];
  assign bus.o_dec_fire           = fire;
  assign bus.o_redirect_valid     = redir_valid_q;
  assign bus.o_redirect_pc        = redir_pc_q;
  assign bus.o_dbg_drop           = (state_q == ST_DROP);
endmodule

// File: tb/tb_decode_queue_ctrl.sv
// Directed bench for decode_queue_ctrl: per-cycle vector table plus hand-written reset sequences.
module tb_decode_queue_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_queue_ctrl_if #(.ADDR_W(32)) bus ();

  decode_queue_ctrl #(.DEPTH(4), .ADDR_W(32), .FETCH_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic [31:0] pred;
    logic        inc;
    logic [31:0] npc;
    logic        rr;
    logic        fl;
    logic [31:0] flpc;
    logic        e_ready;
    logic        e_dv;
    logic [31:0] e_dpc;
    logic        e_fire;
    logic        e_rv;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic void add(input logic fv, input logic [31:0] pc, input logic [31:0] pred,
                              input logic inc, input logic [31:0] npc, input logic rr,
                              input logic fl, input logic [31:0] flpc,
                              input logic e_ready, input logic e_dv, input logic [31:0] e_dpc,
                              input logic e_fire, input logic e_rv, input logic [31:0] e_rpc);
    vec_t v;
    v.fv = fv; v.pc = pc; v.pred = pred; v.inc = inc; v.npc = npc; v.rr = rr;
    v.fl = fl; v.flpc = flpc; v.e_ready = e_ready; v.e_dv = e_dv; v.e_dpc = e_dpc;
    v.e_fire = e_fire; v.e_rv = e_rv; v.e_rpc = e_rpc;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.i_fetch_valid          = v.fv;
    bus.i_fetch_pc             = v.pc;
    bus.i_fetch_instr          = 32'hA000_0000 ^ v.pc;
    bus.i_fetch_prediction     = v.pred;
    bus.i_fetch_guesses_branch = (v.pred != v.pc + 32'd4);
    bus.i_dec_inconsistency    = v.inc;
    bus.i_dec_new_pc           = v.npc;
    bus.i_rename_ready         = v.rr;
    bus.i_flush                = v.fl;
    bus.i_flush_pc             = v.flpc;
  endtask

  task automatic idle();
    vec_t v;
    v = '{default: '0};
    drive(v);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    @(posedge clk);
    #1 drive(v);
    #3;
    check($sformatf("v%0d ready", i), 32'(bus.o_fetch_ready), 32'(v.e_ready));
    check($sformatf("v%0d dec_valid", i), 32'(bus.o_dec_valid), 32'(v.e_dv));
    check($sformatf("v%0d fire", i), 32'(bus.o_dec_fire), 32'(v.e_fire));
    check($sformatf("v%0d redirect_valid", i), 32'(bus.o_redirect_valid), 32'(v.e_rv));
    check($sformatf("v%0d redirect_pc", i), bus.o_redirect_pc, v.e_rpc);
    if (v.e_dv) begin
      check($sformatf("v%0d dec_pc", i), bus.o_dec_pc, v.e_dpc);
      check($sformatf("v%0d dec_instr", i), bus.o_dec_instr, 32'hA000_0000 ^ v.e_dpc);
    end
  endtask

  task automatic push_one(input logic [31:0] pc);
    vec_t v;
    v = '{default: '0};
    v.fv = 1'b1; v.pc = pc; v.pred = pc + 32'd4;
    @(posedge clk);
    #1 drive(v);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " dec_valid"}, 32'(bus.o_dec_valid), 32'd0);
    check({tag, " redirect_valid"}, 32'(bus.o_redirect_valid), 32'd0);
    check({tag, " ready"}, 32'(bus.o_fetch_ready), 32'd1);
  endtask

  initial begin
    // streaming, order preserved, one fire per cycle
    add(1, 'h100, 'h104, 0, 0,     1, 0, 0,     1, 0, 0,     0, 0, 0);
    add(1, 'h104, 'h108, 0, 0,     1, 0, 0,     1, 1, 'h100, 1, 0, 0);
    add(1, 'h108, 'h10C, 0, 0,     1, 0, 0,     1, 1, 'h104, 1, 0, 0);
    add(0, 0,     0,     0, 0,     1, 0, 0,     1, 1, 'h108, 1, 0, 0);
    add(0, 0,     0,     0, 0,     1, 0, 0,     1, 0, 0,     0, 0, 0);
    // fill to DEPTH, 5th refused, pop with push held does not push
    add(1, 'h110, 'h114, 0, 0,     0, 0, 0,     1, 0, 0,     0, 0, 0);
    add(1, 'h114, 'h118, 0, 0,     0, 0, 0,     1, 1, 'h110, 0, 0, 0);
    add(1, 'h118, 'h11C, 0, 0,     0, 0, 0,     1, 1, 'h110, 0, 0, 0);
    add(1, 'h11C, 'h120, 0, 0,     0, 0, 0,     1, 1, 'h110, 0, 0, 0);
    add(1, 'h120, 'h124, 0, 0,     0, 0, 0,     0, 1, 'h110, 0, 0, 0);
    add(1, 'h120, 'h124, 0, 0,     1, 0, 0,     0, 1, 'h110, 1, 0, 0);
    add(0, 0,     0,     0, 0,     0, 0, 0,     1, 1, 'h114, 0, 0, 0);
    add(0, 0,     0,     0, 0,     1, 0, 0,     1, 1, 'h114, 1, 0, 0);
    add(0, 0,     0,     0, 0,     1, 0, 0,     1, 1, 'h118, 1, 0, 0);
    add(0, 0,     0,     0, 0,     1, 0, 0,     1, 1, 'h11C, 1, 0, 0);
    add(0, 0,     0,     0, 0,     1, 0, 0,     1, 0, 0,     0, 0, 0);
    // mispredict at head 0x200 -> redirect 0x240, two fetches dropped, third queued
    add(1, 'h200, 'h204, 0, 0,     0, 0, 0,     1, 0, 0,     0, 0, 0);
    add(1, 'h204, 'h208, 0, 0,     0, 0, 0,     1, 1, 'h200, 0, 0, 0);
    add(1, 'h208, 'h20C, 1, 'h240, 1, 0, 0,     1, 1, 'h200, 1, 0, 0);
    add(1, 'h300, 'h304, 0, 0,     0, 0, 0,     1, 0, 0,     0, 1, 'h240);
    add(1, 'h304, 'h308, 0, 0,     0, 0, 0,     1, 0, 0,     0, 0, 'h240);
    add(1, 'h308, 'h208, 0, 0,     0, 0, 0,     1, 0, 0,     0, 0, 'h240);
    add(1, 'h30C, 'h310, 0, 0,     0, 0, 0,     1, 1, 'h308, 0, 0, 'h240);
    // false alarm: new_pc equals prediction
    add(0, 0,     0,     1, 'h208, 1, 0, 0,     1, 1, 'h308, 1, 0, 'h240);
    add(0, 0,     0,     0, 0,     0, 0, 0,     1, 1, 'h30C, 0, 0, 'h240);
    // flush collides with a would-be mispredict: flush wins
    add(1, 'h400, 'h404, 1, 'h240, 1, 1, 'h80,  1, 1, 'h30C, 0, 0, 'h240);
    add(0, 0,     0,     0, 0,     0, 0, 0,     1, 0, 0,     0, 1, 'h80);
    // flush in DROP reloads the counter
    add(0, 0,     0,     0, 0,     0, 1, 'h90,  1, 0, 0,     0, 0, 'h80);
    add(1, 'h500, 'h504, 0, 0,     0, 0, 0,     1, 0, 0,     0, 1, 'h90);
    add(1, 'h504, 'h508, 0, 0,     0, 0, 0,     1, 0, 0,     0, 0, 'h90);
    add(1, 'h508, 'h50C, 0, 0,     0, 0, 0,     1, 0, 0,     0, 0, 'h90);
    add(0, 0,     0,     0, 0,     1, 0, 0,     1, 1, 'h508, 1, 0, 'h90);
    add(0, 0,     0,     0, 0,     1, 0, 0,     1, 0, 0,     0, 0, 'h90);

    idle();
    #12;
    check("rst dec_valid", 32'(bus.o_dec_valid), 32'd0);
    check("rst fire", 32'(bus.o_dec_fire), 32'd0);
    check("rst redirect_valid", 32'(bus.o_redirect_valid), 32'd0);
    check("rst redirect_pc", bus.o_redirect_pc, 32'd0);
    check("rst ready", 32'(bus.o_fetch_ready), 32'd1);
    check("rst drop", 32'(bus.o_dbg_drop), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // reset mid-stream with three entries held
    push_one(32'h600);
    push_one(32'h604);
    push_one(32'h608);
    @(posedge clk);
    #1 idle();
    #2;
    check("mid dec_valid before reset", 32'(bus.o_dec_valid), 32'd1);
    check("mid dec_pc before reset", bus.o_dec_pc, 32'h600);
    rst_n = 1'b0;
    #1;
    check_quiet("mid rst");
    check("mid rst redirect_pc", bus.o_redirect_pc, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #3 check_quiet($sformatf("post rst c%0d", c));
    end

    // a registered redirect pulse is cancelled by reset
    @(posedge clk);
    #1 bus.i_flush = 1'b1; bus.i_flush_pc = 32'h44;
    @(posedge clk);
    #1 idle();
    #1;
    check("pulse redirect_valid", 32'(bus.o_redirect_valid), 32'd1);
    check("pulse redirect_pc", bus.o_redirect_pc, 32'h44);
    rst_n = 1'b0;
    #1;
    check("pulse rst redirect_valid", 32'(bus.o_redirect_valid), 32'd0);
    check("pulse rst drop", 32'(bus.o_dbg_drop), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #3 check_quiet($sformatf("post pulse rst c%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
